// File: rtl/afe_pulser_sequencer.sv
// Trigger scheduler feeding afe_pulser: a start issues a train of 1-cycle
// trigs with a fixed spacing and count, and holds a width word for the train.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start, stop start / abort commands, sampled every cycle
//   period      trig-to-trig spacing in clk cycles (clamped to MIN_PERIOD)
//   num_pulses  pulses per train, 0 = run until stop
//   width_in    width code latched on an accepted start
//   trig        1-cycle trigger to afe_pulser
//   width       width code held for the whole train
//   busy        train in progress
//   done        1-cycle pulse when a finite train completes
//   pulse_cnt   trigs issued in the current / last train (saturating)
module afe_pulser_sequencer #(
    parameter int PERIOD_W   = 32,
    parameter int COUNT_W    = 16,
    parameter int MIN_PERIOD = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [COUNT_W-1:0]  num_pulses,
    input  logic [15:0]         width_in,
    output logic                trig,
    output logic [15:0]         width,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  pulse_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [COUNT_W-1:0]  ONE_C = COUNT_W'(1);

    logic [0:0]          state;
    logic [PERIOD_W-1:0] period_l;
    logic [COUNT_W-1:0]  num_l;
    logic [PERIOD_W-1:0] cnt;
    // Set in the cycle the final trig of a finite train is high;
    // the following edge closes the train and raises done.
    logic                last_q;

    logic [PERIOD_W-1:0] period_clamp;
    logic [COUNT_W-1:0]  cnt_inc;

    always_comb begin
        period_clamp = (period < MIN_P) ? MIN_P : period;
        cnt_inc      = (&pulse_cnt) ? pulse_cnt : pulse_cnt + ONE_C;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            period_l  <= '0;
            num_l     <= '0;
            cnt       <= '0;
            last_q    <= 1'b0;
            trig      <= 1'b0;
            width     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            trig <= 1'b0;
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start && !stop) begin
                    // Accepted start: the first trig goes out immediately.
                    state     <= S_RUN;
                    period_l  <= period_clamp;
                    num_l     <= num_pulses;
                    width     <= width_in;
                    cnt       <= period_clamp - 1'b1;
                    trig      <= 1'b1;
                    pulse_cnt <= ONE_C;
                    busy      <= 1'b1;
                    last_q    <= (num_pulses == ONE_C);
                end
            end else begin
                if (stop) begin
                    // Abort wins over a trig that is due this edge.
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    last_q <= 1'b0;
                end else if (last_q) begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    last_q <= 1'b0;
                end else if (cnt == '0) begin
                    trig      <= 1'b1;
                    cnt       <= period_l - 1'b1;
                    pulse_cnt <= cnt_inc;
                    // Continuous trains never end on count, even saturated.
                    last_q    <= (num_l != '0) && (cnt_inc == num_l);
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule
